mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit executing MULT, MULTU, DIV and DIVU. It accepts two 32-bit operands from the execute stage and produces the HI/LO results with one-cycle HI/LO write-enable pulses. These drive the register file's HI_write_enable/LO_write_enable and HI_write_data/LO_write_data inputs directly. While an operation is in flight it holds `busy` so the pipeline can stall MFHI/MFLO and further mult/div issue.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  input  1  system clock, all state updates on rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `start`  input  1  request; accepted only in IDLE
- `op`  input  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU; sampled with `start`
- `operand_a`  input  32  rs value (multiplicand / dividend); sampled with `start`
- `operand_b`  input  32  rt value (multiplier / divisor); sampled with `start`
- `abort`  input  1  cancel in-flight operation (pipeline flush)
- `busy`  output  1  high from cycle after acceptance through the WRITE cycle
- `done`  output  1  one-cycle pulse in WRITE
- `HI_write_enable`  output  1  one-cycle pulse in WRITE
- `LO_write_enable`  output  1  one-cycle pulse in WRITE
- `HI_write_data`  output  32  registered result, high word / remainder
- `LO_write_data`  output  32  registered result, low word / quotient

## Operation
- States: IDLE, CALC, FIX, WRITE.
- IDLE:
  - `start`=1 latches `op`, operand magnitudes and result-sign flags.
  - Clears the 5-bit iteration counter and goes to CALC.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, operating on unsigned magnitudes. After 32 steps (counter = 31) it goes to FIX.
- FIX: applies sign correction and loads `HI_write_data`/`LO_write_data`, then goes to WRITE.
- WRITE: asserts `done` and both write enables, then goes to IDLE.
- Arithmetic:
  - MULT gives the signed 64-bit product; MULTU gives the unsigned 64-bit product. HI = [63:32], LO = [31:0].
  - DIV/DIVU: LO = quotient truncated toward zero, HI = remainder. For DIV the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0, any divide op: LO=0xFFFFFFFF, HI=`operand_a`. CALC still runs its full length.
- Boundaries:
  - `start` while `busy` is ignored, including in the WRITE cycle. Operands are not re-sampled.
  - `abort` in CALC or FIX returns the unit to IDLE on the next edge. No write pulse occurs and the output data registers keep their old value.
  - `abort` in WRITE is ignored: the pulse completes.
  - `abort` together with `start` in IDLE: the abort wins and nothing is accepted.
  - `reset_n` low at any time forces IDLE immediately and clears all outputs, discarding any in-flight operation.
- Output data registers hold the last result until the next FIX.

## Timing
- Reset values: `busy`=0, `done`=0, `HI_write_enable`=0, `LO_write_enable`=0, `HI_write_data`=0, `LO_write_data`=0. State is IDLE.
- `start` is sampled high at the edge ending cycle T. Then:
  - Cycles T+1..T+32: CALC.
  - Cycle T+33: FIX.
  - Cycle T+34: WRITE.
  - `busy` is high over T+1..T+34.
- The result is visible on the data ports from cycle T+34 onward. The register file captures it at that edge.
- Back-to-back issue: the earliest next accepted `start` is in cycle T+35 (the first IDLE cycle).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MDU_SINGLE_CYCLE_MULT_EN`
  - Defined: MULT/MULTU skip CALC. The product is computed with a single-cycle multiplier in IDLE→FIX, so FIX is at T+1, WRITE at T+2, and `busy` is high over T+1..T+2. Divide timing is unchanged.
  - Undefined: multiplies use the 32-cycle iterative path described above. No hardware multiplier is inferred.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, `start` at T → `busy` high T+1..T+34; WRITE at T+34 with HI=0xFFFFFFFE, LO=0x00000001, `done` pulse exactly one cycle.
- MULT 0xFFFFFFFD (-3) × 0x00000007 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. With `MDU_SINGLE_CYCLE_MULT_EN`, the same result arrives with WRITE at T+2.
- DIV 0xFFFFFFF9 (-7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 → LO=0xFFFFFFFF, HI=0x12345678 at T+34.
- `start` pulsed at T+5 and T+34 during a busy op → ignored: operands are not re-sampled and exactly one write pulse occurs. `abort` at T+10 → IDLE at T+11, no enables, data ports unchanged.
- `reset_n` driven low asynchronously mid-CALC (no clock edge) → `busy` and all outputs go to 0 immediately. After release, a new `start` completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. It works on
//   unsigned magnitudes and applies the sign fix-up once, at the end. Results
//   go straight to the register file's HI/LO write ports as one-cycle pulses.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   start, op              request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   operand_a, operand_b   rs / rt values, sampled together with start
//   abort                  pipeline flush; cancels work in CALC or FIX
//   busy                   high from the cycle after acceptance through WRITE
//   done, HI/LO_write_enable  one-cycle pulses in WRITE
//   HI/LO_write_data       registered result (high word/remainder, low word/quotient)
//
// Build option
//   MDU_SINGLE_CYCLE_MULT_EN  when defined, MULT/MULTU use a single-cycle
//                             multiplier and go from IDLE straight to FIX.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        HI_write_enable,
  output logic        LO_write_enable,
  output logic [31:0] HI_write_data,
  output logic [31:0] LO_write_data
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_WRITE} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;     // op[1] of the accepted request
  logic        neg_q;        // product / quotient must be negated
  logic        rem_neg_q;    // remainder takes the dividend's sign
  logic        div_zero_q;   // divisor was zero
  logic [31:0] raw_a_q;      // raw dividend, returned in HI on divide-by-zero
  logic [31:0] opb_q;        // multiplicand (mult) or divisor (div) magnitude
  logic [31:0] acc_hi_q;     // product high / partial remainder
  logic [31:0] acc_lo_q;     // multiplier->product low / dividend->quotient

  // Request decode: signed ops are the ones with op[0] == 0.
  logic        sgn_a, sgn_b;
  logic [31:0] mag_a, mag_b;
  assign sgn_a = ~op[0] & operand_a[31];
  assign sgn_b = ~op[0] & operand_b[31];
  assign mag_a = sgn_a ? -operand_a : operand_a;
  assign mag_b = sgn_b ? -operand_b : operand_b;

`ifdef MDU_SINGLE_CYCLE_MULT_EN
  logic [63:0] mul_full;
  assign mul_full = {32'd0, mag_a} * {32'd0, mag_b};
`endif

  // Shift-add multiply step: add the multiplicand into the high half when the
  // multiplier LSB is set, then shift the 65-bit {carry,hi,lo} right by one.
  logic [32:0] mul_sum;
  logic [31:0] mul_hi_d, mul_lo_d;
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_hi_d = mul_sum[32:1];
  assign mul_lo_d = {mul_sum[0], acc_lo_q[31:1]};

  // Restoring divide step: shift the next dividend bit into the remainder,
  // subtract the divisor when it fits. The difference always fits 32 bits
  // when it is used, so the low-word subtraction is enough.
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [31:0] div_hi_d, div_lo_d;
  assign div_sh   = {acc_hi_q, acc_lo_q[31]};
  assign div_ge   = div_sh >= {1'b0, opb_q};
  assign div_diff = div_sh[31:0] - opb_q;
  assign div_hi_d = div_ge ? div_diff : div_sh[31:0];
  assign div_lo_d = {acc_lo_q[30:0], div_ge};

  // Sign fix-up applied in FIX.
  logic [63:0] prod_d;
  logic [31:0] quot_d, rem_d;
  assign prod_d = neg_q     ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quot_d = neg_q     ? -acc_lo_q : acc_lo_q;
  assign rem_d  = rem_neg_q ? -acc_hi_q : acc_hi_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= 5'd0;
      is_div_q        <= 1'b0;
      neg_q           <= 1'b0;
      rem_neg_q       <= 1'b0;
      div_zero_q      <= 1'b0;
      raw_a_q         <= 32'd0;
      opb_q           <= 32'd0;
      acc_hi_q        <= 32'd0;
      acc_lo_q        <= 32'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      HI_write_enable <= 1'b0;
      LO_write_enable <= 1'b0;
      HI_write_data   <= 32'd0;
      LO_write_data   <= 32'd0;
    end else begin
      done            <= 1'b0;
      HI_write_enable <= 1'b0;
      LO_write_enable <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // abort beats a simultaneous start
          if (start && !abort) begin
            is_div_q   <= op[1];
            neg_q      <= sgn_a ^ sgn_b;
            rem_neg_q  <= sgn_a;
            div_zero_q <= (operand_b == 32'd0);
            raw_a_q    <= operand_a;
            cnt_q      <= 5'd0;
            busy       <= 1'b1;
            if (op[1]) begin
              opb_q    <= mag_b;
              acc_hi_q <= 32'd0;
              acc_lo_q <= mag_a;
              state_q  <= S_CALC;
            end else begin
`ifdef MDU_SINGLE_CYCLE_MULT_EN
              {acc_hi_q, acc_lo_q} <= mul_full;
              state_q              <= S_FIX;
`else
              opb_q    <= mag_a;
              acc_hi_q <= 32'd0;
              acc_lo_q <= mag_b;
              state_q  <= S_CALC;
`endif
            end
          end
        end
        S_CALC: begin
          if (abort) begin
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (is_div_q) begin
              acc_hi_q <= div_hi_d;
              acc_lo_q <= div_lo_d;
            end else begin
              acc_hi_q <= mul_hi_d;
              acc_lo_q <= mul_lo_d;
            end
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (abort) begin
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (!is_div_q) begin
              HI_write_data <= prod_d[63:32];
              LO_write_data <= prod_d[31:0];
            end else if (div_zero_q) begin
              HI_write_data <= raw_a_q;
              LO_write_data <= 32'hFFFF_FFFF;
            end else begin
              HI_write_data <= rem_d;
              LO_write_data <= quot_d;
            end
            done            <= 1'b1;
            HI_write_enable <= 1'b1;
            LO_write_enable <= 1'b1;
            state_q         <= S_WRITE;
          end
        end
        S_WRITE: begin
          // abort and start are both ignored here
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done, HI_write_enable, LO_write_enable;
  logic [31:0] HI_write_data, LO_write_data;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .abort(abort),
    .busy(busy), .done(done),
    .HI_write_enable(HI_write_enable), .LO_write_enable(LO_write_enable),
    .HI_write_data(HI_write_data), .LO_write_data(LO_write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = $signed(a); sb = $signed(b);
    ua = a;          ub = b;
    r  = 64'd0;
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb;   // truncating, remainder sign = dividend
          r  = {sr[31:0], sq[31:0]};
        end else begin
          uq = ua / ub; ur = ua % ub;
          r  = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [1:0] o);
`ifdef MDU_SINGLE_CYCLE_MULT_EN
    return o[1] ? 34 : 2;
`else
    return 34;
`endif
  endfunction

  // Transaction-level model: k = cycles since acceptance (0 = idle).
  int          k = 0, lat = 34;
  logic [63:0] pend = 64'd0, exp_res = 64'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k       <= 0;
      exp_res <= 64'd0;
    end else if (k == 0) begin
      if (start && !abort) begin
        k    <= 1;
        lat  <= lat_of(op);
        pend <= ref_res(op, operand_a, operand_b);
      end
    end else if (k == lat) begin
      k <= 0;
    end else if (abort) begin
      k <= 0;
    end else begin
      if (k + 1 == lat) exp_res <= pend;
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy", {63'd0, busy}, {63'd0, k != 0});
      chk("done", {63'd0, done}, {63'd0, (k != 0) && (k == lat)});
      chk("hi_we", {63'd0, HI_write_enable}, {63'd0, (k != 0) && (k == lat)});
      chk("lo_we", {63'd0, LO_write_enable}, {63'd0, (k != 0) && (k == lat)});
      chk("hi_data", {32'd0, HI_write_data}, {32'd0, exp_res[63:32]});
      chk("lo_data", {32'd0, LO_write_data}, {32'd0, exp_res[31:0]});
    end
  end

  // Directed op: pulse start, wait (bounded) for done, check latency and data.
  task automatic run_dir(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int j;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
    j = 1;
    while (!done && j < 60) begin
      @(negedge clk);
      j++;
    end
    chk({nm, "_lat"}, 64'(j), 64'(lat_of(o)));
    chk({nm, "_hi"}, {32'd0, HI_write_data}, {32'd0, ehi});
    chk({nm, "_lo"}, {32'd0, LO_write_data}, {32'd0, elo});
    @(negedge clk);
    chk({nm, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] c [5];
    c[0] = 32'd0; c[1] = 32'd1; c[2] = 32'hFFFF_FFFF; c[3] = 32'h8000_0000; c[4] = 32'h7FFF_FFFF;
    case ($urandom % 4)
      0: return 32'($urandom % 4);
      1: return 32'($urandom % 1000);
      2: return c[$urandom % 5];
      default: return $urandom;
    endcase
  endfunction

  int pulses;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = 2'b00;
    operand_a = 32'd0; operand_b = 32'd0;

    // model pins
    chk("pin_multu", ref_res(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("pin_mult",  ref_res(2'b00, 32'hFFFF_FFFD, 32'd7),         64'hFFFF_FFFF_FFFF_FFEB);
    chk("pin_div",   ref_res(2'b10, 32'hFFFF_FFF9, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_divov", ref_res(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    chk("pin_div0",  ref_res(2'b11, 32'h1234_5678, 32'd0),         64'h1234_5678_FFFF_FFFF);

    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {62'd0, HI_write_enable, done}, 64'd0);
    chk("rst_data", {HI_write_data, LO_write_data}, 64'd0);
    reset_n = 1'b1;

    run_dir("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_dir("mult",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_dir("div",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_dir("divu",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
    run_dir("divov", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_dir("div0",  2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF);

    // start while busy (T+5 and in WRITE at T+34) is ignored
    @(negedge clk);
    start = 1'b1; op = 2'b11; operand_a = 32'd1000; operand_b = 32'd7;
    pulses = 0;
    for (int j = 1; j <= 36; j++) begin
      @(negedge clk);
      if (done) pulses++;
      start = (j == 5 || j == 34);
      operand_a = $urandom; operand_b = $urandom;
    end
    start = 1'b0;
    chk("ign_pulses", 64'(pulses), 64'd1);
    chk("ign_data", {HI_write_data, LO_write_data}, {32'd6, 32'd142});

    // abort at T+10: idle at T+11, data unchanged, no pulse
    @(negedge clk);
    start = 1'b1; op = 2'b10; operand_a = 32'hFFFF_FFCE; operand_b = 32'd3;
    pulses = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) pulses++;
      abort = (j == 10);
      if (j == 11) chk("abort_idle", {63'd0, busy}, 64'd0);
    end
    abort = 1'b0;
    chk("abort_pulses", 64'(pulses), 64'd0);
    chk("abort_data", {HI_write_data, LO_write_data}, {32'd6, 32'd142});

    // abort together with start in IDLE: nothing accepted
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 2'b01; operand_a = 32'd3; operand_b = 32'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start", {63'd0, busy}, 64'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 2'b11; operand_a = 32'd77; operand_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_data", {HI_write_data, LO_write_data}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_dir("post_rst", 2'b10, 32'hFFFF_FFCE, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFF0);

    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start     = ($urandom % 4 != 0);
      abort     = ($urandom % 64 == 0);
      op        = 2'($urandom);
      operand_a = rnd_opnd();
      operand_b = rnd_opnd();
    end
    start = 1'b0; abort = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
